alu_ctrl_muldiv: RTL
====================

Name: alu_ctrl_muldiv

Overview:
Parametrised successor to the EX-stage ALU controller. It keeps the combinational 4-bit Operation decode from ALUOp/Funct7/Funct3 for base RV32I ops, branches and HALT. It adds RV32M decode and an iterative multiply/divide sequencer that stalls the pipeline while it runs. The block sits between the main Controller/ID-EX register and the ALU/writeback mux.

Parameters:
XLEN, 32, operand and result width; must be ≥ 8 and even.
ENABLE_M, 1, 1 = decode and execute M ops; 0 = M ops are never recognised, and the sequencer is held in IDLE.
CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
valid_i  in  1  ID/EX holds a valid instruction
ALUOp  in  2  00 LW/SW/AUIPC/JALR, 01 branch/HALT, 10 R/I-type, 11 JAL/LUI
Funct7  in  7  instr[31:25]
Funct3  in  3  instr[14:12]
src_a  in  XLEN  rs1 operand
src_b  in  XLEN  rs2 operand
flush_i  in  1  pipeline flush; aborts any M op in progress
Operation  out  4  ALU operation select, combinational
md_sel_o  out  1  combinational; 1 = current instruction is an M op, so writeback takes md_result_o
stall_o  out  1  combinational; hold PC, IF/ID and ID/EX
md_valid_o  out  1  one-cycle pulse: md_result_o is valid
md_result_o  out  XLEN  M-op result, registered, held until the next launch

Behaviour:
- Decode of Operation. It is purely combinational and ignores valid_i.
  - ALUOp 00 → 0010.
  - ALUOp 11 → 1111.
  - ALUOp 10, by Funct3:
    - 000, Funct7 = 0100000 → 0100 (SUB); any other Funct7 → 0111 (ADD/ADDI).
    - 001 → 1001. 010 → 0101. 011 → 0000.
    - 100 → 0011. 110 → 0001. 111 → 0000.
    - 101, Funct7 = 0000000 → 1010; Funct7 = 0100000 → 1011; else 0000.
  - ALUOp 01, by Funct3: 000 → 1000, 001 → 1101, 010 → 0110 (HALT), 100 → 1110, 101 → 1100, else 0000.
- M-op detection: m_op = ENABLE_M & ALUOp == 10 & Funct7 == 0000001.
  - When m_op is true, Operation = 0000 and md_sel_o = 1.
  - When ENABLE_M = 0, Funct7 0000001 takes the base decode above.
- M-op encoding by Funct3: 000 MUL (low XLEN), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, RUN, DONE. Reset → IDLE, with md_valid_o = 0, md_result_o = 0, counter = 0, internal accumulators = 0.
- IDLE:
  - launch = valid_i & m_op & !flush_i.
  - On launch, latch the operand magnitudes, result signs and Funct3.
  - Special cases go straight to DONE (latency 1):
    - Divide-by-zero: DIV/DIVU quotient = all ones; REM/REMU = src_a.
    - Signed overflow (src_a = MIN, src_b = −1): DIV = MIN, REM = 0.
  - Otherwise go to RUN with counter = XLEN.
- RUN:
  - One radix-2 step per cycle, counter decrements.
  - Multiply: unsigned shift-add on magnitudes into a 2·XLEN product.
  - Divide: restoring; quotient and remainder are XLEN each.
  - When counter reaches 1, apply sign correction, register md_result_o and go to DONE.
  - Signed products are negated when the operand signs differ.
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
- DONE: md_valid_o = 1 for exactly this cycle, stall_o = 0, next state IDLE.
  - The held M instruction is consumed here and is not relaunched.
- stall_o = (IDLE & launch) | RUN. Normal latency: launch at T, md_valid_o at T+XLEN+1; stall spans T..T+XLEN.
- flush_i in RUN or DONE → IDLE next cycle, no md_valid_o, md_result_o unchanged. flush_i has priority over completion in the same cycle.
- Asynchronous reset asserted in any state clears everything immediately; no partial result is ever signalled.
- Non-M instructions never stall. md_result_o changes only on the completion edge.

Test Plan:
- Base decode sweep. Drive every ALUOp/Funct3 combination with Funct7 ∈ {0000000, 0100000} and check Operation against the table. Spot checks: ALUOp=10, F3=101, F7=0100000 → 1011; ALUOp=01, F3=010 → 0110; ALUOp=11 → 1111. stall_o must stay 0 throughout.
- MUL timing (XLEN=32). MUL with a=7, b=−3 launched at T → stall_o high T..T+32, md_valid_o only at T+33, md_result_o = 0xFFFFFFEB.
- High-word products. MULH with a=b=0x80000000 → 0x40000000. MULHU with a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU with a=−1, b=2 → 0xFFFFFFFF.
- Divide and remainder. DIV a=−7, b=2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF. DIVU a=100, b=7 → 14; REMU → 2.
- Special cases. DIVU x/0 → 0xFFFFFFFF with md_valid_o at T+1. REM a=5, b=0 → 5. DIV 0x80000000 / −1 → 0x80000000. REM of the same → 0.
- Abort paths.
  - flush_i at T+10 of a DIV → IDLE, no md_valid_o, stall_o low at T+11, md_result_o unchanged.
  - rst_n low at T+5 → all outputs zero immediately, next launch behaves normally.
  - With ENABLE_M=0, F7=0000001, F3=000 → Operation 0111, md_sel_o = 0, no stall.

Source files
------------

// File: rtl/alu_ctrl_muldiv.sv
// rtl/alu_ctrl_muldiv.sv - EX-stage ALU operation decode with an iterative RV32M multiply/divide sequencer
// Base ops decode combinationally; M ops stall the pipeline while a radix-2 shift-add / restoring-divide loop runs.
module alu_ctrl_muldiv #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter int CNT_W    = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush_i,
  output logic [3:0]      Operation,
  output logic            md_sel_o,
  output logic            stall_o,
  output logic            md_valid_o,
  output logic [XLEN-1:0] md_result_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd_q, hi_q, lo_q, md_result_q;

  logic              m_op, launch;
  logic              a_sgn, b_sgn, a_neg, b_neg, res_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum, div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [XLEN-1:0]   hi_d, lo_d, quo_s, rem_s, fin_d;
  logic [2*XLEN-1:0] prod_s;

  assign m_op     = ENABLE_M & (ALUOp == 2'b10) & (Funct7 == 7'b0000001);
  assign launch   = valid_i & m_op & ~flush_i;
  assign md_sel_o = m_op;

  always_comb begin
    Operation = 4'b0000;
    case (ALUOp)
      2'b00: Operation = 4'b0010;
      2'b11: Operation = 4'b1111;
      2'b10: begin
        case (Funct3)
          3'b000: Operation = (Funct7 == 7'b0100000) ? 4'b0100 : 4'b0111;
          3'b001: Operation = 4'b1001;
          3'b010: Operation = 4'b0101;
          3'b100: Operation = 4'b0011;
          3'b101: begin
            if (Funct7 == 7'b0000000)      Operation = 4'b1010;
            else if (Funct7 == 7'b0100000) Operation = 4'b1011;
          end
          3'b110: Operation = 4'b0001;
          default: Operation = 4'b0000;
        endcase
      end
      default: begin
        case (Funct3)
          3'b000: Operation = 4'b1000;
          3'b001: Operation = 4'b1101;
          3'b010: Operation = 4'b0110;
          3'b100: Operation = 4'b1110;
          3'b101: Operation = 4'b1100;
          default: Operation = 4'b0000;
        endcase
      end
    endcase
    if (m_op) Operation = 4'b0000;
  end

  // Signedness per op: MULH/DIV/REM both signed, MULHSU only rs1; MUL low word is sign-agnostic.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (Funct3)
      3'b001, 3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'b010:                 a_sgn = 1'b1;
      default: ;
    endcase
    a_neg   = a_sgn & src_a[XLEN-1];
    b_neg   = b_sgn & src_b[XLEN-1];
    a_mag   = a_neg ? -src_a : src_a;
    b_mag   = b_neg ? -src_b : src_b;
    res_neg = (Funct3[2] & Funct3[1]) ? a_neg : (a_neg ^ b_neg);
  end

  assign div_zero    = Funct3[2] & (src_b == '0);
  assign div_ovf     = Funct3[2] & ~Funct3[0] & (src_a == MIN_VAL) & (src_b == '1);
  assign special_res = div_zero ? (Funct3[1] ? src_a : '1)
                                : (Funct3[1] ? '0 : MIN_VAL);

  // hi/lo hold product-high/multiplier for multiply and remainder/dividend-quotient for divide.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + ({(XLEN+1){lo_q[0]}} & {1'b0, opnd_q});
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
    if (f3_q[2]) begin
      hi_d = div_ge ? div_diff : div_shift[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod_s = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    quo_s  = neg_q ? -lo_d : lo_d;
    rem_s  = neg_q ? -hi_d : hi_d;
    case (f3_q)
      3'b000:                 fin_d = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_d = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_d = quo_s;
      default:                fin_d = rem_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      f3_q        <= '0;
      neg_q       <= 1'b0;
      opnd_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      md_result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch) begin
            f3_q   <= Funct3;
            neg_q  <= res_neg;
            opnd_q <= Funct3[2] ? b_mag : a_mag;
            hi_q   <= '0;
            lo_q   <= Funct3[2] ? a_mag : b_mag;
            if (div_zero | div_ovf) begin
              md_result_q <= special_res;
              state_q     <= DONE;
            end else begin
              cnt_q   <= CNT_W'(XLEN);
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              md_result_q <= fin_d;
              state_q     <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_o     = ((state_q == IDLE) & launch) | (state_q == RUN);
  // A flush landing in DONE suppresses the completion pulse.
  assign md_valid_o  = (state_q == DONE) & ~flush_i;
  assign md_result_o = md_result_q;

endmodule
